// File: rtl/uart_memflash_tx_if.sv
// Handshake bundle between the scene-flash transmit framer and its environment.
// The slave modport is the framer itself. The master modport is the surrounding
// logic: the request producer plus the UART byte transmitter.
interface uart_memflash_tx_if #(
   parameter int MAX_PAYLOAD_BYTES = 32
);

   // Request side: one command byte plus a payload word, byte 0 sent first.
   logic                           req_valid;
   logic                           req_ready;
   logic [7:0]                     req_cmd;
   logic [MAX_PAYLOAD_BYTES*8-1:0] req_data;

   // Byte stream towards the UART transmitter.
   logic                           tx_valid;
   logic                           tx_ready;
   logic [7:0]                     tx_byte;

   // Frame status.
   logic                           busy;
   logic                           done;
   logic                           req_error;

   modport master (
      output req_valid,
      output req_cmd,
      output req_data,
      output tx_ready,
      input  req_ready,
      input  tx_valid,
      input  tx_byte,
      input  busy,
      input  done,
      input  req_error
   );

   modport slave (
      input  req_valid,
      input  req_cmd,
      input  req_data,
      input  tx_ready,
      output req_ready,
      output tx_valid,
      output tx_byte,
      output busy,
      output done,
      output req_error
   );

endinterface

// File: rtl/uart_memflash_tx.sv
// Transmit-side framer for the scene-flash byte protocol.
// It accepts one command plus its payload and emits the command byte first.
// The payload bytes follow, LSB-first, over a valid/ready byte stream.
// The payload length comes from the command code. Unsupported codes are
// consumed and flagged with a single-cycle req_error pulse.
module uart_memflash_tx #(
   parameter int CAM_BYTES         = 9,
   parameter int OBJ_BYTES         = 32,
   parameter int NUM_OBJS_BYTES    = 1,
   parameter int MAX_PAYLOAD_BYTES = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_memflash_tx_if.slave     bus
);

   localparam int DATA_W = MAX_PAYLOAD_BYTES * 8;
   // One extra bit so that a load of LEN-1 with LEN = MAX_PAYLOAD_BYTES
   // always fits without wrapping.
   localparam int CNT_W  = $clog2(MAX_PAYLOAD_BYTES) + 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND_CMD  = 2'd1,
      ST_SEND_DATA = 2'd2
   } state_t;

   // Returns 1 when the command code belongs to a supported frame type.
   function automatic logic cmd_supported(input logic [7:0] cmd);
      logic ok;
      casez (cmd)
         8'b1????0??: ok = 1'b1;   // camera
         8'b0???????: ok = 1'b1;   // object
         8'b1????100: ok = 1'b1;   // object count
         8'b1????101: ok = 1'b1;   // max bounces
         8'b1????11?: ok = 1'b0;   // reserved codes
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Returns the payload length in bytes for a command code. Unsupported codes return 0.
   function automatic logic [CNT_W-1:0] cmd_len(input logic [7:0] cmd);
      logic [CNT_W-1:0] len;
      casez (cmd)
         8'b1????0??: len = CNT_W'(CAM_BYTES);
         8'b0???????: len = CNT_W'(OBJ_BYTES);
         8'b1????100: len = CNT_W'(NUM_OBJS_BYTES);
         8'b1????101: len = {{(CNT_W-1){1'b0}}, 1'b1};
         8'b1????11?: len = {CNT_W{1'b0}};
         default:     len = {CNT_W{1'b0}};
      endcase
      return len;
   endfunction

   state_t              state_r, state_s;
   logic                tx_valid_r, tx_valid_s;
   logic [7:0]          tx_byte_r, tx_byte_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;
   logic                req_error_r, req_error_s;
   // Number of payload bytes still to follow the byte currently presented.
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [DATA_W-1:0]   shift_r, shift_s;

   // Next-state and next-output logic of the framing FSM.
   always_comb begin
      state_s     = state_r;
      tx_valid_s  = tx_valid_r;
      tx_byte_s   = tx_byte_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      req_error_s = 1'b0;
      cnt_s       = cnt_r;
      shift_s     = shift_r;

      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (cmd_supported(bus.req_cmd)) begin
                  // Payload lengths are never zero, so LEN-1 cannot underflow.
                  tx_byte_s  = bus.req_cmd;
                  shift_s    = bus.req_data;
                  cnt_s      = cmd_len(bus.req_cmd) - {{(CNT_W-1){1'b0}}, 1'b1};
                  tx_valid_s = 1'b1;
                  busy_s     = 1'b1;
                  state_s    = ST_SEND_CMD;
               end else begin
                  // The request is consumed and dropped. No byte leaves the block.
                  req_error_s = 1'b1;
                  state_s     = ST_IDLE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SEND_CMD: begin
            if (bus.tx_ready) begin
               tx_byte_s = shift_r[7:0];
               shift_s   = {8'h00, shift_r[DATA_W-1:8]};
               state_s   = ST_SEND_DATA;
            end else begin
               state_s = ST_SEND_CMD;
            end
         end

         ST_SEND_DATA: begin
            if (bus.tx_ready) begin
               if (cnt_r == {CNT_W{1'b0}}) begin
                  tx_valid_s = 1'b0;
                  busy_s     = 1'b0;
                  done_s     = 1'b1;
                  state_s    = ST_IDLE;
               end else begin
                  cnt_s     = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                  tx_byte_s = shift_r[7:0];
                  shift_s   = {8'h00, shift_r[DATA_W-1:8]};
                  state_s   = ST_SEND_DATA;
               end
            end else begin
               state_s = ST_SEND_DATA;
            end
         end

         default: begin
            // An illegal encoding falls back to an idle, silent block.
            tx_valid_s = 1'b0;
            busy_s     = 1'b0;
            state_s    = ST_IDLE;
         end
      endcase
   end

   // State and output registers. An async reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         tx_valid_r  <= 1'b0;
         tx_byte_r   <= 8'h00;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         req_error_r <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         shift_r     <= {DATA_W{1'b0}};
      end else begin
         state_r     <= state_s;
         tx_valid_r  <= tx_valid_s;
         tx_byte_r   <= tx_byte_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         req_error_r <= req_error_s;
         cnt_r       <= cnt_s;
         shift_r     <= shift_s;
      end
   end

   assign bus.req_ready = (state_r == ST_IDLE);
   assign bus.tx_valid  = tx_valid_r;
   assign bus.tx_byte   = tx_byte_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.req_error = req_error_r;

endmodule

// File: tb/tb_uart_memflash_tx.sv
// Self-checking bench for uart_memflash_tx.
// The expected byte stream of each frame comes from the command rules.
// A queue holds the command byte followed by LEN payload bytes.
module tb_uart_memflash_tx;

   localparam int CAM_BYTES      = 9;
   localparam int OBJ_BYTES      = 32;
   localparam int NUM_OBJS_BYTES = 1;
   localparam int MAXP           = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;

   uart_memflash_tx_if #(.MAX_PAYLOAD_BYTES(MAXP)) bus ();

   uart_memflash_tx #(
      .CAM_BYTES(CAM_BYTES),
      .OBJ_BYTES(OBJ_BYTES),
      .NUM_OBJS_BYTES(NUM_OBJS_BYTES),
      .MAX_PAYLOAD_BYTES(MAXP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Payload length from the command code. A return of -1 means the code is rejected.
   function automatic int model_len(input logic [7:0] c);
      if (c[7] == 1'b0) return OBJ_BYTES;
      if (c[2] == 1'b0) return CAM_BYTES;
      if (c[1:0] == 2'd0) return NUM_OBJS_BYTES;
      if (c[1:0] == 2'd1) return 1;
      return -1;
   endfunction

   // Drives one request, then follows the byte stream until done or until the abort point.
   task automatic run_frame(input logic [7:0] cmd, input logic [MAXP*8-1:0] data,
                            input bit bp, input int abort_at);
      logic [7:0] expq[$];
      logic [7:0] exp_b;
      logic [7:0] prev_byte;
      int         len;
      int         sent;
      int         ncyc;
      bit         got_done;
      bit         prev_stall;

      len = model_len(cmd);
      @(negedge clk);
      check("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_cmd   = cmd;
      bus.req_data  = data;
      @(negedge clk);
      bus.req_valid = 1'b0;

      if (len < 0) begin
         check("req_error_pulse", bus.req_error, 1);
         check("tx_valid_rejected", bus.tx_valid, 0);
         check("req_ready_rejected", bus.req_ready, 1);
         @(negedge clk);
         check("req_error_width", bus.req_error, 0);
         check("tx_valid_after_reject", bus.tx_valid, 0);
         return;
      end

      expq.push_back(cmd);
      for (int i = 0; i < len; i++) expq.push_back(data[8*i +: 8]);

      check("tx_valid_after_accept", bus.tx_valid, 1);
      check("busy_after_accept", bus.busy, 1);
      check("req_ready_busy", bus.req_ready, 0);

      sent = 0; ncyc = 0; got_done = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00;
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
         if (prev_stall) begin
            check("stall_valid", bus.tx_valid, 1);
            check("stall_byte", bus.tx_byte, prev_byte);
         end
         if (bus.done) begin
            got_done = 1'b1;
            check("done_vs_error", bus.req_error, 0);
         end else begin
            if (abort_at >= 0 && sent == abort_at) begin
               bus.tx_ready  = 1'b1;
               bus.req_valid = 1'b0;
               rst_n = 1'b0;
               #1;
               check("abort_tx_valid", bus.tx_valid, 0);
               check("abort_busy", bus.busy, 0);
               check("abort_done", bus.done, 0);
               check("abort_tx_byte", bus.tx_byte, 0);
               repeat (2) @(negedge clk);
               rst_n = 1'b1;
               check("abort_req_ready", bus.req_ready, 1);
               for (int k = 0; k < 3; k++) begin
                  @(negedge clk);
                  check("abort_no_bytes", bus.tx_valid, 0);
                  check("abort_no_done", bus.done, 0);
               end
               return;
            end
            bus.tx_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_cmd   = 8'($urandom);
            if (bus.tx_valid && bus.tx_ready) begin
               if (expq.size() == 0) begin
                  check("byte_overrun", sent, len);
               end else begin
                  exp_b = expq.pop_front();
                  check("tx_byte", bus.tx_byte, exp_b);
               end
               sent++;
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_byte  = bus.tx_byte;
            ncyc++;
            @(negedge clk);
         end
      end
      bus.req_valid = 1'b0;
      check("frame_done_seen", got_done, 1);
      check("frame_byte_count", sent, len + 1);
      if (!bp) check("frame_cycles", ncyc, len + 1);
      check("end_tx_valid", bus.tx_valid, 0);
      check("end_busy", bus.busy, 0);
      check("end_req_ready", bus.req_ready, 1);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
   endtask

   initial begin
      logic [MAXP*8-1:0] d;
      logic [7:0]        c;

      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_cmd   = 8'h00;
      bus.req_data  = '0;
      bus.tx_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_byte", bus.tx_byte, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_req_error", bus.req_error, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);

      // Camera frame at full rate.
      d = '0;
      d[71:0] = 72'h090807060504030201;
      run_frame(8'h81, d, 1'b0, -1);

      // Object frame of maximum length under random backpressure.
      d = '0;
      for (int i = 0; i < MAXP; i++) d[8*i +: 8] = 8'(i);
      run_frame(8'h05, d, 1'b1, -1);

      // Single-byte commands.
      d = '0; d[7:0] = 8'h07;
      run_frame(8'h85, d, 1'b0, -1);
      d = '0; d[7:0] = 8'h10;
      run_frame(8'h84, d, 1'b0, -1);

      // Rejected command, followed by a normal frame.
      run_frame(8'h86, d, 1'b0, -1);
      d = '0; d[7:0] = 8'h5A;
      run_frame(8'h85, d, 1'b0, -1);

      // Reset while object payload byte 5 is being presented.
      d = '0;
      for (int i = 0; i < MAXP; i++) d[8*i +: 8] = 8'(i);
      run_frame(8'h05, d, 1'b0, 6);
      d = '0; d[7:0] = 8'h33;
      run_frame(8'h85, d, 1'b0, -1);

      // Random commands, payloads and backpressure.
      for (int n = 0; n < 40; n++) begin
         c = 8'($urandom);
         for (int i = 0; i < MAXP; i++) d[8*i +: 8] = 8'($urandom);
         run_frame(c, d, 1'($urandom_range(0, 1)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_memflash_tx.md
Name: uart_memflash_tx

Overview:
- Transmit-side framer for the scene-flash byte protocol: takes one command plus payload and emits it as a UART byte stream (command byte, then payload bytes LSB-first).
- Used for scene readback and echo to the host, and as the stimulus source for loopback tests of the flash receiver.
- Sits between a request producer (scene memory readback, debug logic) and the UART byte transmitter.
- Both sides use a valid/ready handshake.

Parameters:
- CAM_BYTES, 9: payload length for camera commands.
- OBJ_BYTES, 32: payload length for object commands.
- NUM_OBJS_BYTES, 1: payload length for the object-count command.
- MAX_PAYLOAD_BYTES, 32: width of req_data in bytes. Must be >= every length above.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_cmd  input  8  command byte
- req_data  input  MAX_PAYLOAD_BYTES*8  payload; byte 0 = bits [7:0], sent first
- tx_valid  output  1  tx_byte is valid
- tx_ready  input  1  UART transmitter accepts the byte this cycle
- tx_byte  output  8  byte to transmit
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last byte of a frame is accepted
- req_error  output  1  one-cycle pulse when an unsupported command is rejected

Behaviour:
- Reset (async, rst_n low): state IDLE; tx_valid=0, tx_byte=0, busy=0, done=0, req_error=0; byte counter and payload shift register cleared. req_ready=1 once out of reset.
- Reset asserted mid-frame aborts the frame immediately. No done pulse. No further bytes are emitted.
- Command decode at acceptance, casez, determines payload length LEN:
  - 1????0?? camera: LEN=CAM_BYTES
  - 0??????? object: LEN=OBJ_BYTES
  - 1????100 object count: LEN=NUM_OBJS_BYTES
  - 1????101 max bounces: LEN=1
  - 1????11? unsupported: rejected.
- States: IDLE, SEND_CMD, SEND_DATA.
- IDLE:
  - req_ready=1 (req_ready is 1 only in IDLE).
  - On req_valid with a supported command: latch req_cmd into tx_byte; latch req_data into the shift register; load counter=LEN-1; tx_valid<=1, busy<=1; go to SEND_CMD. tx_valid is therefore high in the cycle after acceptance.
  - On req_valid with an unsupported command: request is consumed; req_error<=1 for one cycle; stay IDLE; no bytes are emitted.
- SEND_CMD: hold tx_byte and tx_valid until tx_ready. On the handshake, tx_byte<=shift[7:0], shift register >>8, go to SEND_DATA. tx_valid stays high with no bubble.
- SEND_DATA: hold the current byte until tx_ready. On the handshake:
  - If counter==0: tx_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
  - Otherwise: counter-1; next byte from the shift register.
- tx_byte and tx_valid must not change while tx_valid=1 and tx_ready=0.
- tx_ready while tx_valid=0 is ignored.
- Changes on req_* while not in IDLE are ignored.
- Frame length = 1+LEN bytes. Payload bytes above LEN are never sent.
- Throughput:
  - With tx_ready held high: one byte per cycle.
  - A new request can be accepted the cycle after done. Minimum one idle cycle between frames.
- done and req_error are never high in the same cycle.
- Counter width is $clog2(MAX_PAYLOAD_BYTES)+1 bits. It must not wrap for LEN=MAX_PAYLOAD_BYTES.

Test Plan:
- Camera frame: req_cmd=8'h81, req_data[71:0]=72'h090807060504030201, tx_ready=1 → tx bytes 81,01,02,...,09 on 10 consecutive cycles; done pulses once; req_ready returns high; tx_valid high in the cycle after acceptance.
- Backpressure: object frame cmd=8'h05, OBJ_BYTES=32, data byte i = i; tx_ready toggles 1/0 pseudo-randomly → 33 bytes 05,00..1F in order; tx_byte stable during every stall; no duplicated or dropped bytes.
- Short commands:
  - cmd=8'h85, data[7:0]=8'h07 → bytes 85,07, then done.
  - cmd=8'h84, data[7:0]=8'h10 → bytes 84,10, then done.
- Unsupported cmd=8'h86 → req_error pulse for one cycle; tx_valid stays 0; req_ready stays high. A following cmd=8'h85 frame is sent normally.
- Async reset asserted while sending object byte 5 → tx_valid, busy, done drop immediately with no clock. After release, req_ready=1 and a new 8'h85 frame is sent correctly.
- Loopback: feed the tx byte stream into the flash receiver → its cam/obj/num_objs/max_bounces data and write-enable match the values sent, for one frame of each command type.
